core_mem_arb: RTL and testbench

Arbiter for the core's single external memory port. The port is shared between instruction-fetch refill (I side) and data load/store (D side). It serialises one transaction at a time and routes the response back to the owner. It also drives the cache-stall inputs of the hazard controller: stall_dec from the I side, stall_wb from the D side.

---
 rtl/core_mem_arb_if.sv | 39 +++
 rtl/core_mem_arb.sv | 104 ++++++++++
 tb/tb_core_mem_arb.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arb_if.sv
// Bus bundle between the I/D requesters, the memory port and core_mem_arb.
// The slave modport is the arbiter's view, the master modport is the requester/memory side.
interface core_mem_arb_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [BE_W-1:0]   d_be;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [BE_W-1:0]   m_be;
   logic              m_ack;
   logic [DATA_W-1:0] m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, m_be
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, m_be
   );
endinterface

// File: rtl/core_mem_arb.sv
// Shares the single external memory port between I-fetch refill and D load/store,
// with a starvation bound on the I side and cache-stall outputs to the hazard controller.
module core_mem_arb #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   core_mem_arb_if.slave    bus,
   output logic             stall_dec_out,
   output logic             stall_wb_out
);
   localparam int unsigned BE_W = DATA_W / 8;
   localparam int unsigned SCNT_W = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GNT_I = 2'd1;
   localparam logic [1:0] ST_GNT_D = 2'd2;

   localparam logic [SCNT_W-1:0] SCNT_LIM = SCNT_W'(STARVE_MAX);
   localparam logic [SCNT_W-1:0] SCNT_SAT = '1;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
   localparam logic [DATA_W-1:0] DATA_ZERO = '0;
   localparam logic [BE_W-1:0]   BE_ZERO   = '0;
   localparam logic [BE_W-1:0]   BE_ALL    = '1;

   logic [1:0]        state_q, state_d;
   logic [SCNT_W-1:0] scnt_q, scnt_d;
   logic              starve;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         scnt_q  <= '0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
      end
   end

   assign starve = bus.i_req && (scnt_q == SCNT_LIM);

   // Arbitration happens only from IDLE; a grant is held until m_ack.
   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.d_req && !starve) begin
               state_d = ST_GNT_D;
               if (bus.i_req) begin
                  scnt_d = (scnt_q == SCNT_SAT) ? SCNT_SAT : scnt_q + SCNT_W'(1);
               end else begin
                  scnt_d = '0;
               end
            end else if (bus.i_req) begin
               state_d = ST_GNT_I;
               scnt_d  = '0;
            end
         end
         ST_GNT_I, ST_GNT_D: begin
            if (bus.m_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Memory-side mux follows the owner; acks and stalls are same-cycle decodes.
   always_comb begin
      bus.m_req   = 1'b0;
      bus.m_we    = 1'b0;
      bus.m_addr  = ADDR_ZERO;
      bus.m_wdata = DATA_ZERO;
      bus.m_be    = BE_ZERO;
      bus.i_ack   = 1'b0;
      bus.d_ack   = 1'b0;
      case (state_q)
         ST_GNT_I: begin
            bus.m_req  = 1'b1;
            bus.m_addr = bus.i_addr;
            bus.m_be   = BE_ALL;
            bus.i_ack  = bus.m_ack;
         end
         ST_GNT_D: begin
            bus.m_req   = 1'b1;
            bus.m_we    = bus.d_we;
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
            bus.m_be    = bus.d_be;
            bus.d_ack   = bus.m_ack;
         end
         default: ;
      endcase
   end

   assign bus.i_rdata   = bus.m_rdata;
   assign bus.d_rdata   = bus.m_rdata;
   assign stall_dec_out = bus.i_req & ~bus.i_ack;
   assign stall_wb_out  = bus.d_req & ~bus.d_ack;
endmodule

// File: tb/tb_core_mem_arb.sv
// Directed bench for core_mem_arb: inputs change 1ns after the rising edge,
// outputs are sampled mid-cycle, expected values are hand-computed.
module tb_core_mem_arb;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic clk;
   logic rst_n;
   logic stall_dec_out;
   logic stall_wb_out;

   int total;
   int bad;

   core_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   core_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus.slave),
      .stall_dec_out (stall_dec_out),
      .stall_wb_out  (stall_wb_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Advance to the next cycle: 1ns after the rising edge, ready for new inputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle sample point, well away from either edge.
   task automatic settle();
      #3;
   endtask

   task automatic idle_inputs();
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.d_be    = '0;
      bus.m_ack   = 1'b0;
      bus.m_rdata = '0;
   endtask

   initial begin
      string seq;
      int    grants;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle_inputs();

      // 1: reset held with both requests and pulsing m_ack
      tick();
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      bus.i_addr = 32'h100;
      bus.d_addr = 32'h200;
      for (int c = 0; c < 3; c++) begin
         bus.m_ack = (c != 1);
         settle();
         chk("rst_m_req", 32'(bus.m_req), 32'd0);
         chk("rst_i_ack", 32'(bus.i_ack), 32'd0);
         chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
         chk("rst_m_addr", bus.m_addr, 32'h0);
         chk("rst_stall_dec", 32'(stall_dec_out), 32'd1);
         tick();
      end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      tick();
      settle();
      chk("idle_m_req", 32'(bus.m_req), 32'd0);
      tick();

      // 2: single I refill, ack at cycle 3
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h100;
      settle();
      chk("i_c0_m_req", 32'(bus.m_req), 32'd0);
      chk("i_c0_stall_dec", 32'(stall_dec_out), 32'd1);
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 3) begin
            bus.m_ack   = 1'b1;
            bus.m_rdata = 32'hDEADBEEF;
         end
         settle();
         chk("i_m_req", 32'(bus.m_req), 32'd1);
         chk("i_m_addr", bus.m_addr, 32'h100);
         chk("i_m_we", 32'(bus.m_we), 32'd0);
         chk("i_m_be", 32'(bus.m_be), 32'hF);
         chk("i_d_ack", 32'(bus.d_ack), 32'd0);
         if (c < 3) begin
            chk("i_ack_early", 32'(bus.i_ack), 32'd0);
            chk("i_stall_dec", 32'(stall_dec_out), 32'd1);
         end else begin
            chk("i_ack", 32'(bus.i_ack), 32'd1);
            chk("i_rdata", bus.i_rdata, 32'hDEADBEEF);
            chk("i_stall_dec_ack", 32'(stall_dec_out), 32'd0);
         end
      end
      tick();
      idle_inputs();
      settle();
      chk("i_c4_m_req", 32'(bus.m_req), 32'd0);
      tick();

      // 3: simultaneous I and D, D wins, I follows after the bubble
      bus.i_req   = 1'b1;
      bus.i_addr  = 32'h100;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h200;
      bus.d_wdata = 32'h55AA;
      bus.d_be    = 4'h3;
      settle();
      chk("s_c0_m_req", 32'(bus.m_req), 32'd0);
      tick();
      settle();
      chk("s_c1_m_req", 32'(bus.m_req), 32'd1);
      chk("s_c1_m_we", 32'(bus.m_we), 32'd1);
      chk("s_c1_m_addr", bus.m_addr, 32'h200);
      chk("s_c1_m_wdata", bus.m_wdata, 32'h55AA);
      chk("s_c1_m_be", 32'(bus.m_be), 32'h3);
      chk("s_c1_d_ack", 32'(bus.d_ack), 32'd0);
      tick();
      bus.m_ack = 1'b1;
      settle();
      chk("s_c2_d_ack", 32'(bus.d_ack), 32'd1);
      chk("s_c2_i_ack", 32'(bus.i_ack), 32'd0);
      chk("s_c2_stall_wb", 32'(stall_wb_out), 32'd0);
      chk("s_c2_stall_dec", 32'(stall_dec_out), 32'd1);
      tick();
      bus.m_ack  = 1'b0;
      bus.d_req  = 1'b0;
      bus.d_we   = 1'b0;
      settle();
      chk("s_c3_m_req", 32'(bus.m_req), 32'd0);
      chk("s_c3_m_be", 32'(bus.m_be), 32'h0);
      tick();
      settle();
      chk("s_c4_m_req", 32'(bus.m_req), 32'd1);
      chk("s_c4_m_addr", bus.m_addr, 32'h100);
      chk("s_c4_m_we", 32'(bus.m_we), 32'd0);
      tick();
      bus.m_ack = 1'b1;
      settle();
      chk("s_c5_i_ack", 32'(bus.i_ack), 32'd1);
      chk("s_c5_d_ack", 32'(bus.d_ack), 32'd0);
      tick();
      idle_inputs();
      tick();

      // 4: both held continuously, starvation bound forces I after 4 D grants
      bus.i_req   = 1'b1;
      bus.i_addr  = 32'h100;
      bus.d_req   = 1'b1;
      bus.d_addr  = 32'h200;
      bus.d_wdata = 32'h1;
      bus.d_be    = 4'hF;
      seq    = "";
      grants = 0;
      for (int c = 0; c < 60 && grants < 6; c++) begin
         bus.m_ack = 1'b0;
         #1;
         if (bus.m_req) begin
            seq = {seq, (bus.m_addr == 32'h200) ? "D" : "I"};
            grants++;
            bus.m_ack = 1'b1;
         end
         tick();
      end
      idle_inputs();
      chk("starve_grants", 32'(grants), 32'd6);
      chk("starve_order", 32'(seq == "DDDDID"), 32'd1);
      if (seq != "DDDDID") $display("FAIL starve_seq: got=%s exp=DDDDID", seq);
      tick();
      tick();

      // 5: reset one cycle before m_ack aborts the D grant
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h300;
      tick();
      settle();
      chk("ab_c1_m_req", 32'(bus.m_req), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n     = 1'b1;
      bus.d_req = 1'b0;
      bus.m_ack = 1'b1;
      settle();
      chk("ab_c2_m_req", 32'(bus.m_req), 32'd0);
      chk("ab_c2_d_ack", 32'(bus.d_ack), 32'd0);
      chk("ab_c2_m_addr", bus.m_addr, 32'h0);
      tick();
      bus.m_ack = 1'b0;
      settle();
      chk("ab_c3_m_req", 32'(bus.m_req), 32'd0);
      tick();

      // 6: stray m_ack while idle
      bus.m_ack = 1'b1;
      settle();
      chk("stray_i_ack", 32'(bus.i_ack), 32'd0);
      chk("stray_d_ack", 32'(bus.d_ack), 32'd0);
      tick();
      bus.m_ack = 1'b0;
      settle();
      chk("stray_m_req", 32'(bus.m_req), 32'd0);
      tick();
      bus.d_req = 1'b1;
      tick();
      settle();
      chk("stray_then_d_m_req", 32'(bus.m_req), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
